supervised_counter: RTL and testbench
=====================================

SUPERVISED_COUNTER -- requirements
Module: supervised_counter

Interface
REQ-001 Parameter WIDTH, default 32: count width in bits.
REQ-002 Parameter BURST_W, default 16: width of burst_len.
REQ-003 Parameter FAST_TAP, default 24, and SLOW_TAP, default 27: count bit driving humanClock; both SHALL be < WIDTH.
REQ-004 CLK  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous clear: count 0, flags 0, state IDLE; lower priority than reset.
REQ-007 enable  input  1  level; free-run while high.
REQ-008 step  input  1  single increment per rising edge.
REQ-009 burst_start  input  1  start an N-increment burst.
REQ-010 burst_len  input  BURST_W  burst length N, sampled with burst_start.
REQ-011 fast  input  1  selects the humanClock tap.
REQ-012 limit_en / limit  input  1 / WIDTH  halt-on-match enable and match value.
REQ-013 count  output  WIDTH  counter value.
REQ-014 running / halted / wrapped  output  1 each  state RUN or BURST / state HALT / sticky rollover flag.
REQ-015 humanClock  output  1  visible slow clock.

Function
REQ-016 States IDLE, RUN, BURST, HALT; control priority reset > clear > enable > burst_start > step.
REQ-017 IDLE or RUN with enable=1: count+1 on the same edge, next state RUN; RUN with enable=0: no increment, next state IDLE.
REQ-018 IDLE with enable=0, burst_start=1, burst_len=N>0: increment on the same edge; remaining=N-1; next state BURST if N>1, else IDLE; N=0 is ignored.
REQ-019 BURST: increment every cycle, remaining-1; return to IDLE on the edge where remaining was 1; enable, burst_start and step ignored; exactly N increments total.
REQ-020 step: a registered copy of step detects rising edges; each edge in IDLE with enable=0 and burst_start=0 gives exactly one increment; edges in RUN, BURST or HALT are discarded, not queued; held-high step gives one increment only.
REQ-021 Increments wrap modulo 2^WIDTH; all-ones to 0 sets wrapped=1 until reset or clear.
REQ-022 Limit: any increment with limit_en=1 whose result equals limit loads count=limit and enters HALT on that edge; not applied when limit_en=0.
REQ-023 HALT: count frozen; inputs other than reset and clear have no effect; clear returns to IDLE with count 0.
REQ-024 running=1 in RUN and BURST only; halted=1 in HALT only; both registered from state.
REQ-025 humanClock = fast ? count[FAST_TAP] : count[SLOW_TAP], combinational from count, no extra latency.

Reset
REQ-026 reset=1 at any edge, including mid-burst or in HALT: count=0, state IDLE, remaining=0, wrapped=0, step edge register=0, running=0, halted=0; no initial-block reliance.
REQ-027 A step held high through reset deassertion SHALL NOT produce an increment.

Configuration
REQ-028 Macro SUPERVISED_COUNTER_CAPTURE_EN defined: adds input capture (1) and output captured (WIDTH, reset 0); a capture=1 edge loads captured with the pre-edge count value; clear zeroes it.
REQ-029 Macro undefined: capture ports and register absent; all other behaviour identical.

Verification
REQ-030 Reset, enable=1 for 10 cycles then 0 -> count=10, running=1 during those cycles, then 0, state IDLE.
REQ-031 burst_start with burst_len=5, enable=1 asserted mid-burst -> count=5, running high exactly 5 cycles, enable ignored until burst ends, then RUN resumes.
REQ-032 step held high 20 cycles, then 3 one-cycle pulses -> count=4; pulses during RUN do not change count beyond enable increments.
REQ-033 limit_en=1, limit=7, enable=1 -> count stops at 7, halted=1, running=0; clear -> count=0, halted=0.
REQ-034 WIDTH=4, enable=1 for 17 cycles -> count=1, wrapped=1; FAST_TAP=1, SLOW_TAP=3: humanClock follows count[1] with fast=1, count[3] with fast=0.
REQ-035 reset asserted mid-burst (burst_len=100, 40 cycles in) -> count=0, running=0 next edge, no further increments.

Source files
------------

// File: rtl/supervised_counter.sv
// Supervised up-counter with free-run, burst and single-step modes, halt-on-limit and a visible slow clock.
// Optional capture register is built when SUPERVISED_COUNTER_CAPTURE_EN is defined.
module supervised_counter #(
    parameter int WIDTH    = 32,
    parameter int BURST_W  = 16,
    parameter int FAST_TAP = 24,
    parameter int SLOW_TAP = 27
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic               i_step,
    input  logic               i_burst_start,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic               i_fast,
    input  logic               i_limit_en,
    input  logic [WIDTH-1:0]   i_limit,
`ifdef SUPERVISED_COUNTER_CAPTURE_EN
    input  logic               i_capture,
    output logic [WIDTH-1:0]   o_captured,
`endif
    output logic [WIDTH-1:0]   o_count,
    output logic               o_running,
    output logic               o_halted,
    output logic               o_wrapped,
    output logic               o_humanClock
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_nxt;
    logic [WIDTH-1:0]   w_count_inc;
    logic [BURST_W-1:0] r_remaining;
    logic [BURST_W-1:0] w_remaining_nxt;
    logic               r_wrapped;
    logic               w_wrapped_nxt;
    logic               r_step_d;
    logic               r_step_hold;
    logic               r_running;
    logic               r_halted;
    logic               w_step_edge;
    logic               w_inc;

    assign w_count_inc = r_count + WIDTH'(1);

    // r_step_hold masks a step level that was already high while reset was asserted
    assign w_step_edge = i_step & ~r_step_d & ~r_step_hold;

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_inc           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_inc       = 1'b1;
                    w_state_nxt = S_RUN;
                end else if (i_burst_start) begin
                    if (i_burst_len != '0) begin
                        w_inc           = 1'b1;
                        w_remaining_nxt = i_burst_len - BURST_W'(1);
                        w_state_nxt     = (i_burst_len == BURST_W'(1)) ? S_IDLE : S_BURST;
                    end
                end else if (w_step_edge) begin
                    w_inc = 1'b1;
                end
            end
            S_RUN: begin
                if (i_enable) begin
                    w_inc = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BURST: begin
                w_inc           = 1'b1;
                w_remaining_nxt = r_remaining - BURST_W'(1);
                if (r_remaining == BURST_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_count_nxt   = r_count;
        w_wrapped_nxt = r_wrapped;
        if (w_inc) begin
            w_count_nxt = w_count_inc;
            if (r_count == '1) begin
                w_wrapped_nxt = 1'b1;
            end
            // A limit match overrides whatever mode the increment came from
            if (i_limit_en && (w_count_inc == i_limit)) begin
                w_state_nxt     = S_HALT;
                w_remaining_nxt = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_remaining <= '0;
            r_wrapped   <= 1'b0;
            r_step_d    <= 1'b0;
            r_step_hold <= i_step;
            r_running   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_step_d    <= i_step;
            r_step_hold <= 1'b0;
            if (i_clear) begin
                r_state     <= S_IDLE;
                r_count     <= '0;
                r_remaining <= '0;
                r_wrapped   <= 1'b0;
                r_running   <= 1'b0;
                r_halted    <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_count     <= w_count_nxt;
                r_remaining <= w_remaining_nxt;
                r_wrapped   <= w_wrapped_nxt;
                r_running   <= (w_state_nxt == S_RUN) || (w_state_nxt == S_BURST);
                r_halted    <= (w_state_nxt == S_HALT);
            end
        end
    end

`ifdef SUPERVISED_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] r_captured;

    always_ff @(posedge CLK) begin
        if (reset || i_clear) begin
            r_captured <= '0;
        end else if (i_capture) begin
            r_captured <= r_count;
        end
    end

    assign o_captured = r_captured;
`endif

    assign o_count      = r_count;
    assign o_running    = r_running;
    assign o_halted     = r_halted;
    assign o_wrapped    = r_wrapped;
    assign o_humanClock = i_fast ? r_count[FAST_TAP] : r_count[SLOW_TAP];

endmodule

// File: tb/tb_supervised_counter.sv
// Self-checking bench for supervised_counter: directed scenarios plus randomized stimulus
// compared every cycle against a behavioural model of the counter's rules.
module tb_supervised_counter;

    localparam int W        = 4;
    localparam int BW       = 8;
    localparam int CNT_MASK = (1 << W) - 1;

    logic          CLK = 1'b0;
    logic          reset;
    logic          i_clear;
    logic          i_enable;
    logic          i_step;
    logic          i_burst_start;
    logic [BW-1:0] i_burst_len;
    logic          i_fast;
    logic          i_limit_en;
    logic [W-1:0]  i_limit;
    logic [W-1:0]  o_count;
    logic          o_running;
    logic          o_halted;
    logic          o_wrapped;
    logic          o_humanClock;
`ifdef SUPERVISED_COUNTER_CAPTURE_EN
    logic          i_capture;
    logic [W-1:0]  o_captured;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // model state: count, increments still owed by a burst, free-run flag, halt, sticky wrap
    int m_count;
    int m_rem;
    bit m_run;
    bit m_halt;
    bit m_wrap;
    bit m_step_prev;
    int m_cap;

    supervised_counter #(
        .WIDTH   (W),
        .BURST_W (BW),
        .FAST_TAP(1),
        .SLOW_TAP(3)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .i_clear      (i_clear),
        .i_enable     (i_enable),
        .i_step       (i_step),
        .i_burst_start(i_burst_start),
        .i_burst_len  (i_burst_len),
        .i_fast       (i_fast),
        .i_limit_en   (i_limit_en),
        .i_limit      (i_limit),
`ifdef SUPERVISED_COUNTER_CAPTURE_EN
        .i_capture    (i_capture),
        .o_captured   (o_captured),
`endif
        .o_count      (o_count),
        .o_running    (o_running),
        .o_halted     (o_halted),
        .o_wrapped    (o_wrapped),
        .o_humanClock (o_humanClock)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_inc();
        m_count = (m_count + 1) & CNT_MASK;
        if (m_count == 0) m_wrap = 1'b1;
        if (i_limit_en && m_count == int'(i_limit)) begin
            m_halt = 1'b1;
            m_rem  = 0;
            m_run  = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit rise;
        if (reset) begin
            m_count = 0; m_rem = 0; m_run = 0; m_halt = 0; m_wrap = 0; m_cap = 0;
            // a level already high at reset release is not a new press
            m_step_prev = i_step;
            return;
        end
        rise        = i_step && !m_step_prev;
        m_step_prev = i_step;
        if (i_clear) begin
            m_count = 0; m_rem = 0; m_run = 0; m_halt = 0; m_wrap = 0; m_cap = 0;
            return;
        end
`ifdef SUPERVISED_COUNTER_CAPTURE_EN
        if (i_capture) m_cap = m_count;
`endif
        if (m_halt) begin
            // frozen
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            model_inc();
        end else if (i_enable) begin
            m_run = 1'b1;
            model_inc();
        end else if (m_run) begin
            m_run = 1'b0;
        end else if (i_burst_start) begin
            if (i_burst_len != 0) begin
                m_rem = int'(i_burst_len) - 1;
                model_inc();
            end
        end else if (rise) begin
            model_inc();
        end
    endtask

    task automatic compare_all();
        int exp_hc;
        exp_hc = i_fast ? ((m_count >> 1) & 1) : ((m_count >> 3) & 1);
        check("count",      32'(o_count),      32'(m_count));
        check("running",    32'(o_running),    32'((m_rem > 0) || m_run));
        check("halted",     32'(o_halted),     32'(m_halt));
        check("wrapped",    32'(o_wrapped),    32'(m_wrap));
        check("humanClock", 32'(o_humanClock), 32'(exp_hc));
`ifdef SUPERVISED_COUNTER_CAPTURE_EN
        check("captured",   32'(o_captured),   32'(m_cap));
`endif
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic quiet_inputs();
        reset = 0; i_clear = 0; i_enable = 0; i_step = 0; i_burst_start = 0;
        i_burst_len = '0; i_limit_en = 0; i_limit = '0;
`ifdef SUPERVISED_COUNTER_CAPTURE_EN
        i_capture = 0;
`endif
    endtask

    task automatic do_reset();
        quiet_inputs();
        reset = 1;
        cycle(2);
        reset = 0;
    endtask

    initial begin
        quiet_inputs();
        i_fast = 0;
        m_count = 0; m_rem = 0; m_run = 0; m_halt = 0; m_wrap = 0; m_step_prev = 0; m_cap = 0;
        reset = 1;
        cycle(2);
        check("reset_count", 32'(o_count), 32'd0);
        check("reset_flags", {28'd0, o_running, o_halted, o_wrapped, 1'b0}, 32'd0);
        reset = 0;

        // free run for 10 cycles then stop
        i_enable = 1;
        cycle(1);
        check("run_started", 32'(o_running), 32'd1);
        cycle(9);
        i_enable = 0;
        cycle(1);
        check("run10_count", 32'(o_count), 32'd10);
        check("run10_idle",  32'(o_running), 32'd0);

        // burst of 5 with enable raised mid-burst
        do_reset();
        i_burst_start = 1; i_burst_len = 8'd5;
        cycle(1);
        i_burst_start = 0; i_burst_len = '0;
        cycle(1);
        i_enable = 1;
        cycle(3);
        check("burst5_count", 32'(o_count), 32'd5);
        cycle(1);
        check("burst_then_run", 32'(o_count), 32'd6);
        check("burst_then_running", 32'(o_running), 32'd1);
        i_enable = 0;
        cycle(2);

        // held step then three pulses, then pulses during RUN
        do_reset();
        i_step = 1;
        cycle(20);
        check("step_held", 32'(o_count), 32'd1);
        for (int p = 0; p < 3; p++) begin
            i_step = 0; cycle(1);
            i_step = 1; cycle(1);
        end
        i_step = 0;
        cycle(1);
        check("step_pulses", 32'(o_count), 32'd4);
        i_enable = 1;
        for (int p = 0; p < 6; p++) begin
            i_step = p[0];
            cycle(1);
        end
        check("step_in_run", 32'(o_count), 32'd10);
        i_enable = 0; i_step = 0;
        cycle(2);

        // limit halt then clear
        do_reset();
        i_limit_en = 1; i_limit = 4'd7; i_enable = 1;
        cycle(12);
        check("limit_count",   32'(o_count),   32'd7);
        check("limit_halted",  32'(o_halted),  32'd1);
        check("limit_running", 32'(o_running), 32'd0);
        i_clear = 1;
        cycle(1);
        i_clear = 0; i_enable = 0; i_limit_en = 0;
        check("clear_count",  32'(o_count),  32'd0);
        check("clear_halted", 32'(o_halted), 32'd0);

        // wrap through all-ones with both taps observed
        do_reset();
        i_enable = 1;
        for (int c = 0; c < 17; c++) begin
            i_fast = c[1];
            cycle(1);
        end
        i_enable = 0;
        check("wrap_count", 32'(o_count),   32'd1);
        check("wrap_flag",  32'(o_wrapped), 32'd1);
        cycle(1);

        // reset mid-burst
        do_reset();
        i_burst_start = 1; i_burst_len = 8'd100;
        cycle(1);
        i_burst_start = 0; i_burst_len = '0;
        cycle(39);
        reset = 1;
        cycle(1);
        reset = 0;
        check("rst_burst_count",   32'(o_count),   32'd0);
        check("rst_burst_running", 32'(o_running), 32'd0);
        cycle(5);
        check("rst_burst_stays", 32'(o_count), 32'd0);

        // step held high across reset release
        quiet_inputs();
        reset = 1; i_step = 1;
        cycle(2);
        reset = 0;
        cycle(5);
        check("step_thru_reset", 32'(o_count), 32'd0);
        i_step = 0;
        cycle(1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset         = ($urandom_range(0, 299) == 0);
            i_clear       = ($urandom_range(0, 59) == 0);
            i_enable      = ($urandom_range(0, 3) == 0);
            i_burst_start = ($urandom_range(0, 7) == 0);
            i_burst_len   = ($urandom_range(0, 4) == 0) ? BW'($urandom_range(0, 40))
                                                         : BW'($urandom_range(0, 6));
            i_step        = ($urandom_range(0, 1) == 1);
            i_fast        = ($urandom_range(0, 1) == 1);
            i_limit_en    = ($urandom_range(0, 5) == 0);
            i_limit       = W'($urandom_range(0, CNT_MASK));
`ifdef SUPERVISED_COUNTER_CAPTURE_EN
            i_capture     = ($urandom_range(0, 9) == 0);
`endif
            cycle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
